// File: rtl/sobel_column_feeder.sv
// Purpose: buffers a SIZE x WIDTH pixel strip, then streams it out one column per cycle for a Sobel filter.
// Latency: first column is registered one clock after the last pixel is accepted; strip takes SIZE*WIDTH + WIDTH + 1 cycles.
// Backpressure: in_ready is high only while loading; the column stream has no backpressure and never gaps.
//
// Ports:
//   clk, rst              sole clock, asynchronous active-high reset
//   start                 one-cycle request to begin loading a strip (honoured only in IDLE)
//   in_pixel/in_valid     row-major pixel input, accepted when in_valid && in_ready
//   in_ready              high while the feeder is loading
//   col_out[SIZE-1:0]     one pixel column, index 0 is the top row
//   col_valid             col_out holds a valid column
//   col_first/col_last    col_out holds column 0 / column WIDTH-1
//   strip_done            one-cycle pulse after the last column
module sobel_column_feeder #(
    parameter int SIZE  = 3,
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in_pixel,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] col_out [SIZE-1:0],
    output logic       col_valid,
    output logic       col_first,
    output logic       col_last,
    output logic       strip_done
);

    localparam int RW  = $clog2(SIZE);
    // col_cnt must reach WIDTH in STREAM to mark the end-of-strip cycle.
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int CIW = $clog2(WIDTH);

    localparam logic [RW-1:0] ROW_LAST = RW'(SIZE - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COL_END  = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [RW-1:0]  row_cnt;
    logic [CW-1:0]  col_cnt;
    logic [CIW-1:0] col_idx;
    logic           accept;
    logic           load_last;

    // Strip storage; contents are don't-care until reloaded, so no reset.
    logic [7:0] pix_buf [SIZE][WIDTH];

    assign col_idx   = col_cnt[CIW-1:0];
    assign accept    = in_valid && in_ready;
    assign load_last = accept && (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (load_last) state_nxt = STREAM;
            STREAM:  if (col_cnt == COL_END) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state == LOAD);
    end

    // Counters and registered column outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt    <= '0;
            col_cnt    <= '0;
            col_valid  <= 1'b0;
            col_first  <= 1'b0;
            col_last   <= 1'b0;
            strip_done <= 1'b0;
            for (int r = 0; r < SIZE; r++) begin
                col_out[r] <= '0;
            end
        end else begin
            strip_done <= 1'b0;
            case (state)
                IDLE: begin
                    row_cnt <= '0;
                    col_cnt <= '0;
                end
                LOAD: begin
                    if (accept) begin
                        if (load_last) begin
                            row_cnt <= '0;
                            col_cnt <= '0;
                        end else if (col_cnt == COL_LAST) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + 1'b1;
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (col_cnt == COL_END) begin
                        // One cycle past the last column: close the stream; col_out holds.
                        col_valid  <= 1'b0;
                        col_first  <= 1'b0;
                        col_last   <= 1'b0;
                        strip_done <= 1'b1;
                        col_cnt    <= '0;
                    end else begin
                        for (int r = 0; r < SIZE; r++) begin
                            col_out[r] <= pix_buf[r][col_idx];
                        end
                        col_valid <= 1'b1;
                        col_first <= (col_cnt == '0);
                        col_last  <= (col_cnt == COL_LAST);
                        col_cnt   <= col_cnt + 1'b1;
                    end
                end
                default: begin
                    row_cnt <= '0;
                    col_cnt <= '0;
                end
            endcase
        end
    end

    // Buffer write: pixel k lands at row k/WIDTH, column k%WIDTH.
    always_ff @(posedge clk) begin
        if (accept) begin
            pix_buf[row_cnt][col_idx] <= in_pixel;
        end
    end

endmodule

// File: tb/tb_sobel_column_feeder.sv
module tb_sobel_column_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_pixel = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] col_out [2:0];
    logic       col_valid, col_first, col_last, strip_done;

    logic       start_b = 1'b0;
    logic [7:0] in_pixel_b = 8'd0;
    logic       in_valid_b = 1'b0;
    logic       in_ready_b;
    logic [7:0] col_out_b [4:0];
    logic       col_valid_b, col_first_b, col_last_b, strip_done_b;

    int checks = 0;
    int passed = 0;

    int basic_px [9] = '{60, 121, 88, 82, 174, 127, 71, 216, 165};
    int exp_basic [3][3] = '{'{60, 82, 71}, '{121, 174, 216}, '{88, 127, 165}};
    int ld [9];

    sobel_column_feeder #(.SIZE(3), .WIDTH(3)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_pixel(in_pixel), .in_valid(in_valid),
        .in_ready(in_ready), .col_out(col_out), .col_valid(col_valid),
        .col_first(col_first), .col_last(col_last), .strip_done(strip_done)
    );

    sobel_column_feeder #(.SIZE(5), .WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_pixel(in_pixel_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .col_out(col_out_b), .col_valid(col_valid_b),
        .col_first(col_first_b), .col_last(col_last_b), .strip_done(strip_done_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a();
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            in_pixel = 8'(ld[k]);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %0b want 0", in_ready); else passed++;
        checks++; if (col_valid !== 1'b0) $display("FAIL reset_col_valid got %0b want 0", col_valid); else passed++;
        checks++; if (col_first !== 1'b0 || col_last !== 1'b0) $display("FAIL reset_first_last got %0b%0b want 00", col_first, col_last); else passed++;
        checks++; if (strip_done !== 1'b0) $display("FAIL reset_strip_done got %0b want 0", strip_done); else passed++;
        for (int r = 0; r < 3; r++) begin
            checks++; if (col_out[r] !== 8'd0) $display("FAIL reset_col_out[%0d] got %0d want 0", r, col_out[r]); else passed++;
        end
        checks++; if (col_valid_b !== 1'b0) $display("FAIL reset_col_valid_b got %0b want 0", col_valid_b); else passed++;
        rst = 1'b0;
        step();
        checks++; if (in_ready !== 1'b0) $display("FAIL idle_in_ready got %0b want 0", in_ready); else passed++;
    endtask

    task automatic test_basic();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL basic_load_ready got %0b want 1", in_ready); else passed++;
        ld = basic_px;
        load_a();
        checks++; if (in_ready !== 1'b0) $display("FAIL basic_stream_ready got %0b want 0", in_ready); else passed++;
        checks++; if (col_valid !== 1'b0) $display("FAIL basic_early_valid got %0b want 0", col_valid); else passed++;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (col_valid !== 1'b1) $display("FAIL basic_valid c%0d got %0b want 1", c, col_valid); else passed++;
            checks++; if (col_first !== 1'(c == 0)) $display("FAIL basic_first c%0d got %0b want %0b", c, col_first, c == 0); else passed++;
            checks++; if (col_last !== 1'(c == 2)) $display("FAIL basic_last c%0d got %0b want %0b", c, col_last, c == 2); else passed++;
            for (int r = 0; r < 3; r++) begin
                checks++; if (col_out[r] !== 8'(exp_basic[c][r])) $display("FAIL basic_col c%0d r%0d got %0d want %0d", c, r, col_out[r], exp_basic[c][r]); else passed++;
            end
        end
        step();
        checks++; if (col_valid !== 1'b0) $display("FAIL basic_end_valid got %0b want 0", col_valid); else passed++;
        checks++; if (strip_done !== 1'b1) $display("FAIL basic_done got %0b want 1", strip_done); else passed++;
        checks++; if (col_last !== 1'b0) $display("FAIL basic_end_last got %0b want 0", col_last); else passed++;
        for (int r = 0; r < 3; r++) begin
            checks++; if (col_out[r] !== 8'(exp_basic[2][r])) $display("FAIL basic_hold r%0d got %0d want %0d", r, col_out[r], exp_basic[2][r]); else passed++;
        end
        step();
        checks++; if (strip_done !== 1'b0) $display("FAIL basic_done_clear got %0b want 0", strip_done); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL basic_idle_ready got %0b want 0", in_ready); else passed++;
    endtask

    task automatic test_stall();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            in_pixel = 8'(basic_px[k]);
            step();
            in_valid = 1'b0;
            in_pixel = 8'hEE;
            if (k < 8) begin
                for (int s = 0; s < 2; s++) begin
                    checks++; if (in_ready !== 1'b1) $display("FAIL stall_ready k%0d s%0d got %0b want 1", k, s, in_ready); else passed++;
                    step();
                end
            end
        end
        checks++; if (col_valid !== 1'b0) $display("FAIL stall_early_valid got %0b want 0", col_valid); else passed++;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (col_valid !== 1'b1) $display("FAIL stall_valid c%0d got %0b want 1", c, col_valid); else passed++;
            for (int r = 0; r < 3; r++) begin
                checks++; if (col_out[r] !== 8'(exp_basic[c][r])) $display("FAIL stall_col c%0d r%0d got %0d want %0d", c, r, col_out[r], exp_basic[c][r]); else passed++;
            end
        end
        step();
        checks++; if (strip_done !== 1'b1) $display("FAIL stall_done got %0b want 1", strip_done); else passed++;
        step();
    endtask

    task automatic test_ignored();
        in_valid = 1'b1;
        in_pixel = 8'd255;
        step();
        step();
        checks++; if (in_ready !== 1'b0) $display("FAIL ign_idle_ready got %0b want 0", in_ready); else passed++;
        checks++; if (col_valid !== 1'b0) $display("FAIL ign_idle_valid got %0b want 0", col_valid); else passed++;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL ign_load_ready got %0b want 1", in_ready); else passed++;
        ld = basic_px;
        load_a();
        for (int c = 0; c < 3; c++) begin
            if (c == 1) start = 1'b1;
            step();
            start = 1'b0;
            checks++; if (col_valid !== 1'b1) $display("FAIL ign_valid c%0d got %0b want 1", c, col_valid); else passed++;
            for (int r = 0; r < 3; r++) begin
                checks++; if (col_out[r] !== 8'(exp_basic[c][r])) $display("FAIL ign_col c%0d r%0d got %0d want %0d", c, r, col_out[r], exp_basic[c][r]); else passed++;
            end
        end
        step();
        checks++; if (strip_done !== 1'b1) $display("FAIL ign_done got %0b want 1", strip_done); else passed++;
        step();
        checks++; if (in_ready !== 1'b0) $display("FAIL ign_start_latched got %0b want 0", in_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        step();
        start = 1'b0;
        ld = basic_px;
        load_a();
        step();
        step();
        step();
        checks++; if (col_last !== 1'b1) $display("FAIL b2b_first_last got %0b want 1", col_last); else passed++;
        step();
        checks++; if (strip_done !== 1'b1) $display("FAIL b2b_done got %0b want 1", strip_done); else passed++;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b_load_ready got %0b want 1", in_ready); else passed++;
        checks++; if (strip_done !== 1'b0) $display("FAIL b2b_done_clear got %0b want 0", strip_done); else passed++;
        for (int k = 0; k < 9; k++) ld[k] = 200;
        load_a();
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (col_valid !== 1'b1) $display("FAIL b2b_valid c%0d got %0b want 1", c, col_valid); else passed++;
            for (int r = 0; r < 3; r++) begin
                checks++; if (col_out[r] !== 8'd200) $display("FAIL b2b_col c%0d r%0d got %0d want 200", c, r, col_out[r]); else passed++;
            end
        end
        step();
        checks++; if (strip_done !== 1'b1) $display("FAIL b2b_done2 got %0b want 1", strip_done); else passed++;
        step();
    endtask

    task automatic test_scaling();
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_valid_b = 1'b1;
            in_pixel_b = 8'(k);
            step();
        end
        in_valid_b = 1'b0;
        checks++; if (col_valid_b !== 1'b0) $display("FAIL scale_early_valid got %0b want 0", col_valid_b); else passed++;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (col_valid_b !== 1'b1) $display("FAIL scale_valid c%0d got %0b want 1", c, col_valid_b); else passed++;
            checks++; if (col_first_b !== 1'(c == 0)) $display("FAIL scale_first c%0d got %0b want %0b", c, col_first_b, c == 0); else passed++;
            checks++; if (col_last_b !== 1'(c == 3)) $display("FAIL scale_last c%0d got %0b want %0b", c, col_last_b, c == 3); else passed++;
            for (int r = 0; r < 5; r++) begin
                checks++; if (col_out_b[r] !== 8'(4 * r + c)) $display("FAIL scale_col c%0d r%0d got %0d want %0d", c, r, col_out_b[r], 4 * r + c); else passed++;
            end
        end
        step();
        checks++; if (col_valid_b !== 1'b0) $display("FAIL scale_end_valid got %0b want 0", col_valid_b); else passed++;
        checks++; if (strip_done_b !== 1'b1) $display("FAIL scale_done got %0b want 1", strip_done_b); else passed++;
        step();
        checks++; if (strip_done_b !== 1'b0) $display("FAIL scale_done_clear got %0b want 0", strip_done_b); else passed++;
    endtask

    task automatic test_reset_mid_stream();
        start = 1'b1;
        step();
        start = 1'b0;
        ld = basic_px;
        load_a();
        step();
        step();
        checks++; if (col_out[0] !== 8'd121) $display("FAIL rstm_col2 got %0d want 121", col_out[0]); else passed++;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (col_valid !== 1'b0) $display("FAIL rstm_valid got %0b want 0", col_valid); else passed++;
        checks++; if (col_first !== 1'b0 || col_last !== 1'b0) $display("FAIL rstm_first_last got %0b%0b want 00", col_first, col_last); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL rstm_ready got %0b want 0", in_ready); else passed++;
        for (int r = 0; r < 3; r++) begin
            checks++; if (col_out[r] !== 8'd0) $display("FAIL rstm_col_out r%0d got %0d want 0", r, col_out[r]); else passed++;
        end
        step();
        rst = 1'b0;
        step();
        step();
        checks++; if (col_valid !== 1'b0) $display("FAIL rstm_no_col3 got %0b want 0", col_valid); else passed++;
        checks++; if (strip_done !== 1'b0) $display("FAIL rstm_done got %0b want 0", strip_done); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL rstm_idle_ready got %0b want 0", in_ready); else passed++;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL rstm_restart got %0b want 1", in_ready); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_ignored();
        test_back_to_back();
        test_scaling();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sobel_column_feeder.md
SOBEL_COLUMN_FEEDER -- requirements
Module: sobel_column_feeder

Interface
REQ-001 Parameter SIZE, default 3: rows per strip, which is the column height delivered to the Sobel filter.
REQ-002 Parameter WIDTH, default 8: pixels per row, which is the number of columns per strip.
REQ-003 Legal ranges SHALL be SIZE >= 3 and WIDTH >= 2; other values are unsupported.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin loading a strip.
REQ-007 in_pixel  input  8  unsigned pixel, row-major order.
REQ-008 in_valid  input  1  in_pixel is valid this cycle.
REQ-009 in_ready  output  1  feeder accepts a pixel this cycle.
REQ-010 col_out  output  8 x SIZE (unpacked array [SIZE-1:0])  one pixel column; index 0 is the top row; matches the Sobel filter's arr_in.
REQ-011 col_valid  output  1  col_out holds a valid column this cycle.
REQ-012 col_first / col_last  output  1 each  col_out holds column 0 / column WIDTH-1.
REQ-013 strip_done  output  1  one-cycle pulse after the last column is emitted.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD and STREAM.
REQ-015 IDLE SHALL go to LOAD on the edge where start=1; start SHALL be ignored in LOAD and STREAM.
REQ-016 in_ready SHALL be combinational, equal to (state==LOAD); it SHALL be 0 in IDLE, STREAM and during reset.
REQ-017 A pixel SHALL be accepted on each edge where in_valid && in_ready; in_pixel SHALL be ignored otherwise.
REQ-018 Accepted pixel k (0 to SIZE*WIDTH-1) SHALL be written to buffer row k/WIDTH, column k%WIDTH; the counters are row_cnt (0 to SIZE-1) and col_cnt (0 to WIDTH-1), with col_cnt wrapping and row_cnt incrementing on each wrap.
REQ-019 The edge that accepts pixel SIZE*WIDTH-1 (edge E0) SHALL move LOAD to STREAM and clear both counters.
REQ-020 In STREAM, on edge Ei (i = 1 to WIDTH), the feeder SHALL register col_out[r] <= buf[r][i-1] for every r, with col_valid <= 1.
REQ-021 col_first <= 1 only at E1, and col_last <= 1 only at EWIDTH.
REQ-022 col_valid SHALL stay high for exactly WIDTH consecutive cycles, with no gaps; the downstream Sobel filter has no backpressure.
REQ-023 At edge E(WIDTH+1), the feeder SHALL clear col_valid, col_first and col_last, set strip_done <= 1, and move to IDLE.
REQ-024 strip_done SHALL clear on the following edge.
REQ-025 While col_valid=0, col_out SHALL hold its last value; there is no requirement to zero it.
REQ-026 A new start SHALL be honoured in the cycle strip_done is high, because the state is already IDLE.
REQ-027 Latency from the last accepted pixel to the first valid column SHALL be one clock, and strip throughput SHALL be SIZE*WIDTH load cycles plus WIDTH+1 stream cycles.
REQ-028 Stalls (in_valid=0 during LOAD) SHALL hold the counters and state indefinitely.
REQ-029 The data path SHALL be a pure copy: no arithmetic on pixel values, full 8-bit width preserved.

Reset
REQ-030 Asserting rst SHALL immediately force state=IDLE, row_cnt=0, col_cnt=0, col_out all 0, and col_valid, col_first, col_last, strip_done all 0.
REQ-031 Buffer contents are not reset; they are don't-care until reloaded.
REQ-032 Reset mid-LOAD or mid-STREAM SHALL abort the strip; after release the feeder SHALL wait in IDLE for start, with no partial column emitted.

Verification
REQ-033 Basic strip (SIZE=3, WIDTH=3): start, then load 60,121,88,82,174,127,71,216,165 -> col_out {60,82,71}, {121,174,216}, {88,127,165} on 3 consecutive cycles; col_first on the 1st, col_last on the 3rd, then strip_done for 1 cycle.
REQ-034 Stalled load: the same data with in_valid=0 for 2 cycles after each pixel -> identical columns; in_ready stays high throughout LOAD; column output starts exactly 1 cycle after the 9th pixel is accepted.
REQ-035 Ignored inputs: in_valid=1 in IDLE with in_pixel=255, and start pulsed during STREAM -> no buffer write, no state change, stream completes normally.
REQ-036 Back-to-back strips: start asserted in the strip_done cycle, second strip all 200 -> LOAD entered next edge; second strip outputs {200,200,200} x3.
REQ-037 Reset mid-stream: rst asserted after the 2nd column -> all outputs 0 immediately, no 3rd column, IDLE after release.
REQ-038 Scaling: SIZE=5, WIDTH=4, pixel k = k -> column c = {c, 4+c, 8+c, 12+c, 16+c}, with col_valid high for exactly 4 cycles.
